// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, data widths and the operand bundle
// carried by the command scheduler.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MUL  = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [OP_W-1:0]   op_t;

  typedef struct packed {
    data_t a;
    data_t b;
    op_t   f;
  } operands_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Single-clock FIFO with registered occupancy; dout shows the head entry
// combinationally. DEPTH must be a power of two.
module alu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity,
  // which keeps the array a plain RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sched.sv
// Command scheduler around a registered 8-bit ALU: buffers tagged commands,
// issues them under output credits and collects results in order.
module alu_cmd_sched
  import alu_pkg::*;
#(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_f,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_f,
  input  logic [DATA_W-1:0] alu_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic [TAG_W-1:0]  out_tag,
  output logic [OP_W-1:0]   out_f
);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    operands_t op;
    tag_t      tag;
  } cmd_t;

  typedef struct packed {
    data_t y;
    tag_t  tag;
    op_t   f;
  } res_t;

  localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

  cmd_t              in_din, in_head;
  logic              in_full, in_empty;
  logic [IN_CW-1:0]  in_count;
  res_t              out_din, out_head;
  logic              out_full, out_empty;
  logic [OUT_CW-1:0] out_count;

  logic              issue;
  logic [OUT_CW:0]   committed;
  logic              s1_vld, s2_vld;
  tag_t              s1_tag, s2_tag;
  op_t               s1_f, s2_f;

  assign in_ready = !rst && !in_full;
  assign in_din   = {in_a, in_b, in_f, in_tag};

  alu_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .din   (in_din),
    .pop   (issue),
    .dout  (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  // Every issued command owns an output slot until it is popped; counting
  // pops from this same cycle is deliberately skipped.
  assign committed = (OUT_CW+1)'(s1_vld) + (OUT_CW+1)'(s2_vld) + (OUT_CW+1)'(out_count);
  assign issue     = !in_empty && (committed < (OUT_CW+1)'(OUT_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_f  <= '0;
      s1_vld <= 1'b0;
      s1_tag <= '0;
      s1_f   <= '0;
      s2_vld <= 1'b0;
      s2_tag <= '0;
      s2_f   <= '0;
    end else begin
      s1_vld <= issue;
      if (issue) begin
        alu_a  <= in_head.op.a;
        alu_b  <= in_head.op.b;
        alu_f  <= in_head.op.f;
        s1_tag <= in_head.tag;
        s1_f   <= in_head.op.f;
      end
      s2_vld <= s1_vld;
      s2_tag <= s1_tag;
      s2_f   <= s1_f;
    end
  end

  // The ALU registers alu_* on the edge that moves S1 into S2, so alu_y
  // lines up with the S2 tag.
  assign out_din = {alu_y, s2_tag, s2_f};

  alu_sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_vld),
    .din   (out_din),
    .pop   (out_valid && out_ready),
    .dout  (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  assign out_valid = !out_empty;
  assign out_y     = out_valid ? out_head.y   : '0;
  assign out_tag   = out_valid ? out_head.tag : '0;
  assign out_f     = out_valid ? out_head.f   : '0;

  capture_no_overflow: assert property (@(posedge clk) disable iff (rst) s2_vld |-> !out_full);
  in_count_bounded:    assert property (@(posedge clk) disable iff (rst) in_count <= IN_CW'(IN_DEPTH));

endmodule

// File: tb/tb_alu_cmd_sched.sv
// Scoreboard bench for alu_cmd_sched with a registered ALU model attached to
// alu_a/alu_b/alu_f/alu_y.
module tb_alu_cmd_sched;
  import alu_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [7:0]       in_a, in_b;
  logic [2:0]       in_f;
  logic [TAG_W-1:0] in_tag;
  logic [7:0]       alu_a, alu_b, alu_y;
  logic [2:0]       alu_f;
  logic             out_valid, out_ready;
  logic [7:0]       out_y;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_f;

  always #5 clk = ~clk;

  alu_cmd_sched #(.IN_DEPTH(4), .OUT_DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_f(in_f), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .out_f(out_f)
  );

  // Registered ALU attached to the scheduler, cleared by the shared reset.
  always @(posedge clk or posedge rst) begin
    if (rst) alu_y <= '0;
    else begin
      case (alu_f)
        3'd0: alu_y <= alu_a & alu_b;
        3'd1: alu_y <= alu_a | alu_b;
        3'd2: alu_y <= ~(alu_a & alu_b);
        3'd3: alu_y <= ~(alu_a | alu_b);
        3'd4: alu_y <= alu_a + alu_b;
        3'd5: alu_y <= alu_a - alu_b;
        3'd6: alu_y <= alu_a * alu_b;
        default: alu_y <= ~alu_a;
      endcase
    end
  end

  // Expected result computed with plain integer arithmetic.
  function automatic int ref_result(int f, int a, int b);
    case (f)
      0:       return a & b;
      1:       return a | b;
      2:       return 255 - (a & b);
      3:       return 255 - (a | b);
      4:       return (a + b) % 256;
      5:       return (a - b + 256) % 256;
      6:       return (a * b) % 256;
      default: return 255 - a;
    endcase
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [14:0] exp_q[$];
  int          acc_cyc[$];
  int          pop_cyc[$];
  int          acc_total   = 0;
  int          pop_total   = 0;
  int          ready_drops = 0;
  int          cyc         = 0;
  logic        rand_bp     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: handshakes observed here complete at the next rising edge.
  always @(negedge clk) begin
    logic [14:0] e;
    if (!rst) begin
      if (!in_ready) ready_drops++;
      if (in_valid && in_ready) begin
        exp_q.push_back({8'(ref_result(int'(in_f), int'(in_a), int'(in_b))), in_tag, in_f});
        acc_cyc.push_back(cyc + 1);
        acc_total++;
      end
      if (out_valid && out_ready) begin
        pop_cyc.push_back(cyc + 1);
        pop_total++;
        if (exp_q.size() == 0) check("unexpected_result", {17'b0, out_y, out_tag, out_f}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("result_y_tag_f", {17'b0, out_y, out_tag, out_f}, {17'b0, e});
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                      input logic [TAG_W-1:0] tag);
    int t = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_f = f; in_tag = tag;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_scoreboard", exp_q.size(), 0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base, pb, d0;
    logic [7:0] hy;
    logic [TAG_W-1:0] ht;
    logic [2:0] hf;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_f = '0; in_tag = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_f", alu_f, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y_tag_f", {out_y, out_tag, out_f}, 0);
    #11 rst = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);
    tick(1);

    // Single ADD: result visible after the third edge following acceptance
    out_ready = 1'b1;
    d0 = ready_drops;
    acc_cyc.delete(); pop_cyc.delete();
    send(8'h0F, 8'h01, OP_ADD, 4'd3);
    check("latency_e0_valid", out_valid, 0);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      check("latency_valid", out_valid, (k == 3));
    end
    check("single_y", out_y, 8'h10);
    check("single_tag", out_tag, 4'd3);
    check("single_f", out_f, 3'd4);
    wait_idle();
    check("single_pop_edge", (pop_cyc.size() > 0) ? pop_cyc[0] - acc_cyc[0] : -1, 4);
    check("single_no_ready_drop", ready_drops - d0, 0);

    // Wrap and truncation cases
    send(8'h00, 8'h01, OP_SUB,  4'd1);
    send(8'h10, 8'h10, OP_MUL,  4'd2);
    send(8'h0F, 8'h11, OP_MUL,  4'd3);
    send(8'hA5, 8'h00, OP_NOT,  4'd4);
    send(8'hF0, 8'hFF, OP_NAND, 4'd5);
    send(8'hFF, 8'h02, OP_ADD,  4'd6);
    send(8'h0C, 8'h0A, OP_NOR,  4'd7);
    wait_idle();

    // Throughput: 16 back-to-back commands
    d0 = ready_drops;
    acc_cyc.delete(); pop_cyc.delete();
    for (int t = 0; t < 16; t++)
      send(8'($urandom), 8'($urandom), 3'($urandom), 4'(t));
    wait_idle();
    check("tp_results", pop_cyc.size(), 16);
    check("tp_first_latency", (pop_cyc.size() > 0) ? pop_cyc[0] - acc_cyc[0] : -1, 4);
    for (int i = 1; i < 16 && i < pop_cyc.size(); i++)
      check("tp_consecutive", pop_cyc[i] - pop_cyc[0], i);
    check("tp_no_ready_drop", ready_drops - d0, 0);

    // Backpressure: accept exactly OUT_DEPTH + IN_DEPTH commands
    out_ready = 1'b0;
    tick(1);
    base = acc_total;
    pb   = pop_total;
    in_valid = 1'b1;
    repeat (20) begin
      in_tag = 4'(acc_total - base);
      in_a = 8'($urandom); in_b = 8'($urandom); in_f = 3'($urandom);
      tick(1);
    end
    in_valid = 1'b0;
    check("bp_accepted", acc_total - base, 8);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);

    // Head stays stable while stalled
    hy = out_y; ht = out_tag; hf = out_f;
    repeat (5) begin
      tick(1);
      check("stall_y", out_y, hy);
      check("stall_tag", out_tag, ht);
      check("stall_f", out_f, hf);
    end
    out_ready = 1'b1;
    wait_idle();
    check("bp_results", pop_total - pb, 8);

    // Randomized traffic with random output backpressure
    rand_bp = 1'b1;
    for (int n = 0; n < 120; n++) begin
      tick($urandom_range(0, 2));
      send(8'($urandom), 8'($urandom), 3'($urandom), 4'($urandom));
    end
    rand_bp = 1'b0;
    tick(1);
    out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a stream
    out_ready = 1'b0;
    for (int n = 0; n < 6; n++)
      send(8'($urandom), 8'($urandom), 3'($urandom), 4'(n + 8));
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_y_tag_f", {out_y, out_tag, out_f}, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_alu", {alu_a, alu_b, alu_f}, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    tick(1);
    pb = pop_total;
    out_ready = 1'b1;
    send(8'h02, 8'h03, OP_ADD, 4'd1);
    tick(3);
    check("post_rst_y", out_y, 8'h05);
    check("post_rst_tag", out_tag, 4'd1);
    wait_idle();
    check("post_rst_results", pop_total - pb, 1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
